lcd_seq_arb: RTL



---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_cmd_fifo.sv | 45 ++++
 rtl/lcd_seq_arb.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD sequencer/arbiter: word bit layout, init ROM, FSM states.
package lcd_pkg;

  localparam int LCD_ON_IDX   = 31;
  localparam int LCD_RS_IDX   = 9;
  localparam int LCD_RW_IDX   = 8;
  localparam int LCD_DATA_IDX = 0;
  localparam int LCD_DATA_W   = 8;

  localparam int INIT_LEN = 6;
  // Entry 0 is issued first: 38, 38, 38, 0C, 01, 06.
  localparam logic [INIT_LEN-1:0][LCD_DATA_W-1:0] INIT_ROM =
    {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

  typedef enum logic [2:0] {
    PWRUP_WAIT = 3'd0,
    INIT_ISSUE = 3'd1,
    INIT_WAIT  = 3'd2,
    IDLE       = 3'd3,
    CPU_ISSUE  = 3'd4,
    CPU_WAIT   = 3'd5
  } lcd_state_t;

  function automatic logic [31:0] init_word(input logic [2:0] idx);
    logic [31:0] w;
    w = '0;
    w[LCD_ON_IDX] = 1'b1;
    w[LCD_DATA_IDX +: LCD_DATA_W] = INIT_ROM[idx];
    return w;
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long busy time.
  function automatic logic is_long_cmd(input logic [31:0] w);
    logic [LCD_DATA_W-1:0] d;
    d = w[LCD_DATA_IDX +: LCD_DATA_W];
    return !w[LCD_RS_IDX] && !w[LCD_RW_IDX] && (d[7:2] == 6'd0) && (d != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO buffering CPU LCD writes; pointers carry one extra wrap bit.
module lcd_cmd_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign o_empty = (wptr_q == rptr_q);
  assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_data  = mem[rptr_q[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/lcd_seq_arb.sv
// Owns the lcd_ctrl command port: runs the HD44780 init sequence, then serves
// buffered CPU writes, enforcing the controller busy time between issues.
module lcd_seq_arb
  import lcd_pkg::*;
#(
  parameter int T_PERIOD_NS = 20,
  parameter int T_PWRUP_US  = 15000,
  parameter int T_CMD_US    = 40,
  parameter int T_CLR_US    = 1640,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpu_vld,
  output logic        o_cpu_rdy,
  input  logic [31:0] i_cpu_word,
  input  logic        i_reinit,
  output logic        o_lcd_vld,
  input  logic        i_lcd_rdy,
  output logic [31:0] o_lcd_word,
  output logic        o_init_done,
  output lcd_state_t  o_dbg_state
);

  // Handshakes: a word moves on any cycle where vld && rdy; once vld is raised,
  // vld and the word stay unchanged until that cycle.

  localparam int N_PWRUP = T_PWRUP_US * 1000 / T_PERIOD_NS;
  localparam int N_CMD   = T_CMD_US * 1000 / T_PERIOD_NS;
  localparam int N_CLR   = T_CLR_US * 1000 / T_PERIOD_NS;
  localparam int N_MAX   = (N_PWRUP > N_CMD) ? ((N_PWRUP > N_CLR) ? N_PWRUP : N_CLR)
                                             : ((N_CMD > N_CLR) ? N_CMD : N_CLR);
  localparam int CW      = $clog2(N_MAX) + 1;

  lcd_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        vld_d;
  logic [31:0] word_d;
  logic        done_d;
  logic        pend_q;
  logic        pend_clr;
  logic        pop;
  logic        lcd_xfer;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_head;

  lcd_cmd_fifo #(
    .W     (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_cpu_vld),
    .i_data  (i_cpu_word),
    .i_pop   (pop),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_cpu_rdy   = !fifo_full;
  assign lcd_xfer    = o_lcd_vld && i_lcd_rdy;
  assign o_dbg_state = state_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= PWRUP_WAIT;
      cnt_q       <= CW'(N_PWRUP);
      idx_q       <= '0;
      o_lcd_vld   <= 1'b0;
      o_lcd_word  <= '0;
      o_init_done <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      o_lcd_vld   <= vld_d;
      o_lcd_word  <= word_d;
      o_init_done <= done_d;
      pend_q      <= i_reinit || (pend_q && !pend_clr);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    vld_d    = o_lcd_vld;
    word_d   = o_lcd_word;
    done_d   = o_init_done;
    pop      = 1'b0;
    pend_clr = 1'b0;
    case (state_q)
      PWRUP_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d = INIT_ISSUE;
          idx_d   = '0;
          vld_d   = 1'b1;
          word_d  = init_word(3'd0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      INIT_ISSUE: begin
        if (lcd_xfer) begin
          state_d = INIT_WAIT;
          vld_d   = 1'b0;
          cnt_d   = is_long_cmd(o_lcd_word) ? CW'(N_CLR - 1) : CW'(N_CMD - 1);
        end
      end
      INIT_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          if (idx_q == 3'(INIT_LEN - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = INIT_ISSUE;
            idx_d   = idx_q + 1'b1;
            vld_d   = 1'b1;
            word_d  = init_word(idx_q + 1'b1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      IDLE: begin
        if (pend_q) begin
          state_d  = PWRUP_WAIT;
          pend_clr = 1'b1;
          done_d   = 1'b0;
          cnt_d    = CW'(N_PWRUP);
        end else if (!fifo_empty) begin
          state_d = CPU_ISSUE;
          pop     = 1'b1;
          vld_d   = 1'b1;
          word_d  = fifo_head;
        end
      end
      CPU_ISSUE: begin
        if (lcd_xfer) begin
          // Two shorter than the init load: the IDLE pop cycle completes the busy time.
          state_d = CPU_WAIT;
          vld_d   = 1'b0;
          cnt_d   = is_long_cmd(o_lcd_word) ? CW'(N_CLR - 2) : CW'(N_CMD - 2);
        end
      end
      CPU_WAIT: begin
        if (cnt_q <= CW'(1)) state_d = IDLE;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = PWRUP_WAIT;
    endcase
  end

endmodule
